// File: rtl/tremolo_lfo_reader_if.sv
// Bus bundle for the tremolo LFO reader: sample-rate control in, ROM read
// port, and the gain word out. The reader uses the slave modport; the
// environment (audio pipeline + ROM) uses the master modport.
interface tremolo_lfo_reader_if #(
    parameter int DWIDTH  = 16,
    parameter int AWIDTH  = 9,
    parameter int PHASE_W = 24
) ();
    logic               sample_tick_i;
    logic [PHASE_W-1:0] rate_i;
    logic [7:0]         depth_i;
    logic [AWIDTH-1:0]  rom_rdaddr_o;
    logic [DWIDTH-1:0]  rom_rddata_i;
    logic [DWIDTH-1:0]  gain_o;
    logic               gain_valid_o;

    modport slave (
        input  sample_tick_i, rate_i, depth_i, rom_rddata_i,
        output rom_rdaddr_o, gain_o, gain_valid_o
    );

    modport master (
        output sample_tick_i, rate_i, depth_i, rom_rddata_i,
        input  rom_rdaddr_o, gain_o, gain_valid_o
    );
endinterface

// File: rtl/tremolo_lfo_reader.sv
// Tremolo LFO reader: phase accumulator stepped at the audio sample strobe,
// quarter-wave sine ROM lookup with quadrant symmetry, depth scaling into a
// unipolar gain word (all-ones = unity).
// Optional feature macro: TREMOLO_LFO_INTERP_EN -- linear interpolation
// between neighbouring ROM entries (second ROM read, latency 6 instead of 4).
module tremolo_lfo_reader #(
    parameter int DWIDTH  = 16,
    parameter int AWIDTH  = 9,
    parameter int PHASE_W = 24
) (
    input logic                   clk_i,
    input logic                   rst_ni,
    tremolo_lfo_reader_if.slave   bus
);
    localparam int FRAC_W = PHASE_W - 2 - AWIDTH;
    localparam logic [DWIDTH-1:0] FULL = '1;

`ifdef TREMOLO_LFO_INTERP_EN
    typedef enum logic [2:0] {IDLE, ADDR0, ADDR1, DATA1, INTERP, OUT} state_t;
`else
    typedef enum logic [1:0] {IDLE, ADDR, DATA, OUT} state_t;
`endif

    state_t             state;
    logic [PHASE_W-1:0] phase;
    logic [1:0]         q_r;
    logic [7:0]         depth_r;
    logic [DWIDTH-1:0]  m_r;
    logic [AWIDTH-1:0]  rdaddr_r;
    logic [DWIDTH-1:0]  gain_r;
    logic               gain_vld_r;

    assign bus.rom_rdaddr_o = rdaddr_r;
    assign bus.gain_o       = gain_r;
    assign bus.gain_valid_o = gain_vld_r;

    // Quadrant decode of the live phase: odd quadrants walk the table backwards.
    logic [1:0]        q_now;
    logic [AWIDTH-1:0] i_now;
    logic [AWIDTH-1:0] addr_now;
    always_comb begin
        q_now    = phase[PHASE_W-1 -: 2];
        i_now    = phase[PHASE_W-3 -: AWIDTH];
        addr_now = q_now[0] ? ~i_now : i_now;
    end

    // Signed sample -> unipolar u -> depth-scaled gain (product truncated, no saturation).
    logic signed [DWIDTH+1:0] s_val;
    logic [DWIDTH+1:0]        u_sum;
    logic [DWIDTH-1:0]        u_val;
    logic [DWIDTH+7:0]        atten;
    logic [DWIDTH-1:0]        gain_next;
    always_comb begin
        s_val     = q_r[1] ? -$signed({2'b00, m_r}) : $signed({2'b00, m_r});
        u_sum     = $unsigned(s_val) + {2'b00, FULL};
        u_val     = u_sum[DWIDTH:1];
        atten     = {8'd0, FULL - u_val} * {{DWIDTH{1'b0}}, depth_r};
        gain_next = FULL - atten[DWIDTH+7:8];
    end

`ifdef TREMOLO_LFO_INTERP_EN
    localparam int PW = DWIDTH + FRAC_W + 1;

    logic [FRAC_W-1:0]  frac_r;
    logic [DWIDTH-1:0]  m0_r;
    logic [DWIDTH-1:0]  m1_r;
    logic [AWIDTH-1:0]  nb_addr;
    logic signed [DWIDTH:0] diff;
    logic signed [PW-1:0]   prod;
    logic signed [PW-1:0]   interp_sum;

    // Neighbour entry in the direction the quadrant walks, clamped at the table ends.
    always_comb begin
        if (!q_r[0])
            nb_addr = (&rdaddr_r) ? rdaddr_r : rdaddr_r + {{(AWIDTH-1){1'b0}}, 1'b1};
        else
            nb_addr = (rdaddr_r == '0) ? rdaddr_r : rdaddr_r - {{(AWIDTH-1){1'b0}}, 1'b1};
    end

    // m = m0 + ((m1-m0) * frac) >>> FRAC_W; the result always lands between m0 and m1.
    always_comb begin
        diff       = $signed({1'b0, m1_r}) - $signed({1'b0, m0_r});
        prod       = $signed({{(PW-DWIDTH-1){diff[DWIDTH]}}, diff})
                   * $signed({{(PW-FRAC_W){1'b0}}, frac_r});
        interp_sum = $signed({{(PW-DWIDTH){1'b0}}, m0_r}) + (prod >>> FRAC_W);
    end

    logic unused_interp;
    assign unused_interp = ^interp_sum[PW-1:DWIDTH];
`endif

    logic unused_bits;
    assign unused_bits = ^{u_sum[DWIDTH+1], u_sum[0], atten[7:0]};

    // Read sequencer: accepts a tick only in IDLE, drives the ROM address and registers the gain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            phase      <= '0;
            q_r        <= '0;
            depth_r    <= '0;
            m_r        <= '0;
            rdaddr_r   <= '0;
            gain_r     <= FULL;
            gain_vld_r <= 1'b0;
`ifdef TREMOLO_LFO_INTERP_EN
            frac_r     <= '0;
            m0_r       <= '0;
            m1_r       <= '0;
`endif
        end else begin
            gain_vld_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.sample_tick_i) begin
                        q_r      <= q_now;
                        depth_r  <= bus.depth_i;
                        phase    <= phase + bus.rate_i;
                        rdaddr_r <= addr_now;
`ifdef TREMOLO_LFO_INTERP_EN
                        frac_r   <= phase[FRAC_W-1:0];
                        state    <= ADDR0;
`else
                        state    <= ADDR;
`endif
                    end
                end
`ifdef TREMOLO_LFO_INTERP_EN
                ADDR0: begin
                    rdaddr_r <= nb_addr;
                    state    <= ADDR1;
                end
                ADDR1: begin
                    m0_r  <= bus.rom_rddata_i;
                    state <= DATA1;
                end
                DATA1: begin
                    m1_r  <= bus.rom_rddata_i;
                    state <= INTERP;
                end
                INTERP: begin
                    m_r   <= interp_sum[DWIDTH-1:0];
                    state <= OUT;
                end
`else
                ADDR: state <= DATA;
                DATA: begin
                    m_r   <= bus.rom_rddata_i;
                    state <= OUT;
                end
`endif
                OUT: begin
                    gain_r     <= gain_next;
                    gain_vld_r <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tremolo_lfo_reader.sv
// Directed bench for tremolo_lfo_reader with a registered ROM model
// holding mem[k] = k*128. Builds with or without TREMOLO_LFO_INTERP_EN.
module tb_tremolo_lfo_reader;
    localparam int DW = 16;
    localparam int AW = 9;
    localparam int PW = 24;
`ifdef TREMOLO_LFO_INTERP_EN
    localparam int  LAT    = 6;
    localparam int  IP2_EXP = 32927;
`else
    localparam int  LAT    = 4;
    localparam int  IP2_EXP = 32895;
`endif

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk_i = ~clk_i;

    tremolo_lfo_reader_if #(.DWIDTH(DW), .AWIDTH(AW), .PHASE_W(PW)) bus ();

    tremolo_lfo_reader #(.DWIDTH(DW), .AWIDTH(AW), .PHASE_W(PW)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    // Quarter-wave ROM model, one-cycle registered read.
    always @(posedge clk_i) bus.rom_rddata_i <= {bus.rom_rdaddr_o, 7'd0};

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // One accepted tick: address at T+1, neighbour at T+2 (interp), pulse only at T+LAT.
    task automatic tick_read(input int exp_addr, input int exp_nb, input int exp_gain, input string tag);
        bus.sample_tick_i = 1'b1;
        step();
        bus.sample_tick_i = 1'b0;
        chk({tag, "/addr"}, 32'(bus.rom_rdaddr_o), exp_addr);
        for (int k = 2; k <= LAT + 1; k++) begin
            step();
`ifdef TREMOLO_LFO_INTERP_EN
            if (k == 2) chk({tag, "/nb_addr"}, 32'(bus.rom_rdaddr_o), exp_nb);
`endif
            chk({tag, "/valid"}, 32'(bus.gain_valid_o), (k == LAT) ? 1 : 0);
            if (k == LAT) chk({tag, "/gain"}, 32'(bus.gain_o), exp_gain);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.sample_tick_i = 1'b0;
        bus.rate_i        = '0;
        bus.depth_i       = '0;

        // Reset state, then idle after release
        rst_ni = 1'b0;
        repeat (3) step();
        chk("rst/gain",  32'(bus.gain_o), 32'hFFFF);
        chk("rst/valid", 32'(bus.gain_valid_o), 0);
        chk("rst/addr",  32'(bus.rom_rdaddr_o), 0);
        rst_ni = 1'b1;
        repeat (3) step();
        chk("idle/gain",  32'(bus.gain_o), 32'hFFFF);
        chk("idle/valid", 32'(bus.gain_valid_o), 0);
        chk("idle/addr",  32'(bus.rom_rdaddr_o), 0);

        // Zero rate, zero depth: unity gain, phase stays put
        tick_read(0, 1, 32'hFFFF, "r0d0_a");
        tick_read(0, 1, 32'hFFFF, "r0d0_b");

        // Quarter-turn steps through all four quadrants, fifth tick wraps
        bus.rate_i  = 24'h400000;
        bus.depth_i = 8'd255;
        tick_read(0,   1,   32895, "q0");
        tick_read(511, 510, 65472, "q1");
        tick_read(0,   1,   32895, "q2");
        tick_read(511, 510, 319,   "q3");
        tick_read(0,   1,   32895, "wrap");

        // Tick at T+2 is dropped: one pulse, one phase advance
        bus.sample_tick_i = 1'b1;
        step();
        bus.sample_tick_i = 1'b0;
        step();
        bus.sample_tick_i = 1'b1;
        step();
        bus.sample_tick_i = 1'b0;
        for (int k = 3; k <= LAT + 1; k++) begin
            chk("drop/valid", 32'(bus.gain_valid_o), (k == LAT) ? 1 : 0);
            if (k == LAT) chk("drop/gain", 32'(bus.gain_o), 65472);
            step();
        end
        tick_read(0, 1, 32895, "after_drop");

        // Reset at T+2 of a read (q=3 in flight): immediate return to reset values
        bus.sample_tick_i = 1'b1;
        step();
        bus.sample_tick_i = 1'b0;
        step();
        rst_ni = 1'b0;
        #1;
        chk("midrst/gain",  32'(bus.gain_o), 32'hFFFF);
        chk("midrst/addr",  32'(bus.rom_rdaddr_o), 0);
        chk("midrst/valid", 32'(bus.gain_valid_o), 0);
        step();
        rst_ni = 1'b1;
        for (int k = 0; k < LAT + 2; k++) begin
            step();
            chk("midrst/no_pulse", 32'(bus.gain_valid_o), 0);
        end
        tick_read(0, 1, 32895, "post_rst");

        // Fractional phase: interpolated halfway value when enabled
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        step();
        bus.rate_i = 24'h001000;
        tick_read(0, 1, 32895,   "ip1");
        tick_read(0, 1, IP2_EXP, "ip2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
